// File: rtl/nx_instr_arbiter.sv
// Arbiter for the node's single-port instruction RAM. Decoder loads have priority.
// The two cores' fetches are shared round-robin, and read data returns one cycle after the grant.
module nx_instr_arbiter #(
    parameter int INSTR_WIDTH = 15,
    parameter int MAX_INSTRS  = 512,
    localparam int ADDR_W     = $clog2(MAX_INSTRS)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   store_core_i,
    input  logic [INSTR_WIDTH-1:0] store_data_i,
    input  logic                   store_valid_i,
    output logic [ADDR_W-1:0]      core_0_populated_o,
    output logic [ADDR_W-1:0]      core_1_populated_o,
    input  logic [ADDR_W-2:0]      core_0_addr_i,
    input  logic                   core_0_rd_i,
    output logic [INSTR_WIDTH-1:0] core_0_data_o,
    output logic                   core_0_stall_o,
    input  logic [ADDR_W-2:0]      core_1_addr_i,
    input  logic                   core_1_rd_i,
    output logic [INSTR_WIDTH-1:0] core_1_data_o,
    output logic                   core_1_stall_o,
    output logic [ADDR_W-1:0]      ram_addr_o,
    output logic [INSTR_WIDTH-1:0] ram_wr_data_o,
    output logic                   ram_wr_en_o,
    output logic                   ram_rd_en_o,
    input  logic [INSTR_WIDTH-1:0] ram_rd_data_i,
    output logic                   overflow_o
);
    localparam logic [ADDR_W-1:0] HALF = ADDR_W'(MAX_INSTRS / 2);

    logic                   rr_reg, rr_next;
    logic                   tag_valid_reg;
    logic                   tag_core_reg;
    logic                   overflow_reg;
    logic [ADDR_W-1:0]      pop_w [2];
    logic [INSTR_WIDTH-1:0] data_w [2];
    logic [ADDR_W-1:0]      store_pop;
    logic                   load_grant, load_drop, fetch_ok;
    logic [1:0]             rd_req, grant;

    assign rd_req    = {core_1_rd_i, core_0_rd_i};
    assign store_pop = store_core_i ? pop_w[1] : pop_w[0];

    // rr_reg = 0 favours core 0; a full region's load gives the slot back to fetches
    always_comb begin
        load_grant = ~rst_i & store_valid_i & (store_pop < HALF);
        load_drop  = ~rst_i & store_valid_i & (store_pop >= HALF);
        fetch_ok   = ~rst_i & ~load_grant;
        grant[0]   = fetch_ok & rd_req[0] & (~rd_req[1] | ~rr_reg);
        grant[1]   = fetch_ok & rd_req[1] & (~rd_req[0] | rr_reg);
        rr_next    = rr_reg;
        if (grant[0]) begin
            rr_next = 1'b1;
        end else if (grant[1]) begin
            rr_next = 1'b0;
        end
    end

    always_comb begin
        ram_addr_o    = '0;
        ram_wr_data_o = '0;
        ram_wr_en_o   = 1'b0;
        ram_rd_en_o   = 1'b0;
        if (load_grant) begin
            ram_wr_en_o   = 1'b1;
            ram_addr_o    = {store_core_i, store_pop[ADDR_W-2:0]};
            ram_wr_data_o = store_data_i;
        end else if (grant[0]) begin
            ram_rd_en_o = 1'b1;
            ram_addr_o  = {1'b0, core_0_addr_i};
        end else if (grant[1]) begin
            ram_rd_en_o = 1'b1;
            ram_addr_o  = {1'b1, core_1_addr_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_reg        <= 1'b0;
            tag_valid_reg <= 1'b0;
            tag_core_reg  <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            rr_reg        <= rr_next;
            tag_valid_reg <= |grant;
            tag_core_reg  <= grant[1];
            overflow_reg  <= overflow_reg | load_drop;
        end
    end

    // Per-core populated counter and fetch capture register
    for (genvar gi = 0; gi < 2; gi++) begin : g_core
        logic [ADDR_W-1:0]      pop_reg;
        logic [INSTR_WIDTH-1:0] cap_reg;
        logic                   hit;

        assign hit = tag_valid_reg && (tag_core_reg == 1'(gi));

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                pop_reg <= '0;
                cap_reg <= '0;
            end else begin
                if (load_grant && (store_core_i == 1'(gi))) begin
                    pop_reg <= pop_reg + ADDR_W'(1);
                end
                if (hit) begin
                    cap_reg <= ram_rd_data_i;
                end
            end
        end

        assign pop_w[gi]  = pop_reg;
        assign data_w[gi] = rst_i ? '0 : (hit ? ram_rd_data_i : cap_reg);
    end

    assign core_0_populated_o = pop_w[0];
    assign core_1_populated_o = pop_w[1];
    assign core_0_data_o      = data_w[0];
    assign core_1_data_o      = data_w[1];
    assign core_0_stall_o     = core_0_rd_i & ~grant[0];
    assign core_1_stall_o     = core_1_rd_i & ~grant[1];
    assign overflow_o         = overflow_reg;
endmodule

// File: tb/tb_nx_instr_arbiter.sv
// Directed bench for nx_instr_arbiter: a cycle-level behavioural model is checked on every negedge.
// Literal expectations pin the scenarios.
module tb_nx_instr_arbiter;
    localparam int IW = 15;
    localparam int DEPTH = 512;
    localparam int HALF = DEPTH / 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          store_core_i;
    logic [IW-1:0] store_data_i;
    logic          store_valid_i;
    logic [8:0]    core_0_populated_o, core_1_populated_o;
    logic [7:0]    core_0_addr_i, core_1_addr_i;
    logic          core_0_rd_i, core_1_rd_i;
    logic [IW-1:0] core_0_data_o, core_1_data_o;
    logic          core_0_stall_o, core_1_stall_o;
    logic [8:0]    ram_addr_o;
    logic [IW-1:0] ram_wr_data_o;
    logic          ram_wr_en_o, ram_rd_en_o;
    logic [IW-1:0] ram_rd_data_i;
    logic          overflow_o;

    int errors = 0;
    int checks = 0;

    nx_instr_arbiter #(.INSTR_WIDTH(IW), .MAX_INSTRS(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .store_core_i(store_core_i), .store_data_i(store_data_i), .store_valid_i(store_valid_i),
        .core_0_populated_o(core_0_populated_o), .core_1_populated_o(core_1_populated_o),
        .core_0_addr_i(core_0_addr_i), .core_0_rd_i(core_0_rd_i),
        .core_0_data_o(core_0_data_o), .core_0_stall_o(core_0_stall_o),
        .core_1_addr_i(core_1_addr_i), .core_1_rd_i(core_1_rd_i),
        .core_1_data_o(core_1_data_o), .core_1_stall_o(core_1_stall_o),
        .ram_addr_o(ram_addr_o), .ram_wr_data_o(ram_wr_data_o),
        .ram_wr_en_o(ram_wr_en_o), .ram_rd_en_o(ram_rd_en_o),
        .ram_rd_data_i(ram_rd_data_i), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Single-port RAM with one-cycle read latency
    logic [IW-1:0] ram_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
        ram_rd_data_i = '0;
    end
    always @(posedge clk_i) begin
        if (ram_wr_en_o) ram_mem[ram_addr_o] <= ram_wr_data_o;
        if (ram_rd_en_o) ram_rd_data_i <= ram_mem[ram_addr_o];
    end

    // Behavioural model: integer counts, a shadow image of RAM contents, and the favoured core
    int m_pop [2];
    int m_mem [DEPTH];
    int m_data [2];
    int m_fav, m_pend_core, m_pend_val;
    bit m_ovf, m_pend;
    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        m_pop[0] = 0; m_pop[1] = 0; m_data[0] = 0; m_data[1] = 0;
        m_fav = 0; m_pend = 0; m_pend_core = 0; m_pend_val = 0; m_ovf = 0;
    end

    always @(negedge clk_i) begin
        int g, e_addr, sc;
        bit ld, rq0, rq1;
        rq0 = core_0_rd_i;
        rq1 = core_1_rd_i;
        if (rst_i) begin
            chk("rst_wr_en", int'(ram_wr_en_o), 0);
            chk("rst_rd_en", int'(ram_rd_en_o), 0);
            chk("rst_addr", int'(ram_addr_o), 0);
            chk("rst_wr_data", int'(ram_wr_data_o), 0);
            chk("rst_stall0", int'(core_0_stall_o), int'(rq0));
            chk("rst_stall1", int'(core_1_stall_o), int'(rq1));
            chk("rst_data0", int'(core_0_data_o), 0);
            chk("rst_data1", int'(core_1_data_o), 0);
            m_pop[0] = 0; m_pop[1] = 0; m_data[0] = 0; m_data[1] = 0;
            m_fav = 0; m_pend = 0; m_ovf = 0;
        end else begin
            chk("m_pop0", int'(core_0_populated_o), m_pop[0]);
            chk("m_pop1", int'(core_1_populated_o), m_pop[1]);
            chk("m_ovf", int'(overflow_o), int'(m_ovf));
            if (m_pend) m_data[m_pend_core] = m_pend_val;
            chk("m_data0", int'(core_0_data_o), m_data[0]);
            chk("m_data1", int'(core_1_data_o), m_data[1]);
            sc = int'(store_core_i);
            ld = store_valid_i && (m_pop[sc] < HALF);
            g = -1;
            e_addr = 0;
            if (ld) begin
                e_addr = sc * HALF + m_pop[sc];
            end else if (rq0 && rq1) begin
                g = m_fav;
            end else if (rq0) begin
                g = 0;
            end else if (rq1) begin
                g = 1;
            end
            if (g == 0) e_addr = int'(core_0_addr_i);
            if (g == 1) e_addr = HALF + int'(core_1_addr_i);
            chk("m_wr_en", int'(ram_wr_en_o), int'(ld));
            chk("m_rd_en", int'(ram_rd_en_o), (g >= 0) ? 1 : 0);
            chk("m_stall0", int'(core_0_stall_o), (rq0 && g != 0) ? 1 : 0);
            chk("m_stall1", int'(core_1_stall_o), (rq1 && g != 1) ? 1 : 0);
            if (ld || g >= 0) chk("m_addr", int'(ram_addr_o), e_addr);
            if (ld) chk("m_wr_data", int'(ram_wr_data_o), int'(store_data_i));
            if (ld) begin
                m_mem[e_addr] = int'(store_data_i);
                m_pop[sc]++;
            end else if (store_valid_i) begin
                m_ovf = 1;
            end
            if (g >= 0) begin
                m_fav = 1 - g;
                m_pend = 1;
                m_pend_core = g;
                m_pend_val = m_mem[e_addr];
            end else begin
                m_pend = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic smp();
        @(negedge clk_i);
    endtask

    task automatic load(input bit core, input int data, input int exp_addr);
        cyc();
        store_valid_i = 1'b1;
        store_core_i = core;
        store_data_i = IW'(data);
        smp();
        chk("load_wr_en", int'(ram_wr_en_o), 1);
        chk("load_addr", int'(ram_addr_o), exp_addr);
    endtask

    initial begin
        int idx0, idx1;
        rst_i = 1'b1;
        store_core_i = 1'b0; store_data_i = '0; store_valid_i = 1'b0;
        core_0_addr_i = '0; core_0_rd_i = 1'b0;
        core_1_addr_i = '0; core_1_rd_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        smp();
        chk("reset_pop0", int'(core_0_populated_o), 0);
        chk("reset_pop1", int'(core_1_populated_o), 0);
        chk("reset_ovf", int'(overflow_o), 0);
        chk("reset_data0", int'(core_0_data_o), 0);

        load(1'b0, 'h11, 0);
        load(1'b0, 'h22, 1);
        load(1'b0, 'h33, 2);
        load(1'b1, 'h44, 256);
        load(1'b1, 'h55, 257);
        cyc();
        store_valid_i = 1'b0;
        smp();
        chk("loaded_pop0", int'(core_0_populated_o), 3);
        chk("loaded_pop1", int'(core_1_populated_o), 2);

        cyc();
        core_0_rd_i = 1'b1; core_0_addr_i = 8'd1;
        smp();
        chk("fetch_stall0", int'(core_0_stall_o), 0);
        cyc();
        core_0_rd_i = 1'b0;
        smp();
        chk("fetch_data0", int'(core_0_data_o), 'h22);
        cyc();
        smp();
        chk("fetch_hold0", int'(core_0_data_o), 'h22);

        // Single core 1 fetch so that the pointer favours core 0 again
        cyc();
        core_1_rd_i = 1'b1; core_1_addr_i = 8'd0;
        smp();
        cyc();
        core_1_rd_i = 1'b0;
        smp();
        chk("fetch_data1", int'(core_1_data_o), 'h44);

        idx0 = 0; idx1 = 0;
        cyc();
        core_0_rd_i = 1'b1; core_1_rd_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            core_0_addr_i = 8'(idx0);
            core_1_addr_i = 8'(idx1);
            smp();
            chk("rr_stall0", int'(core_0_stall_o), i % 2);
            chk("rr_stall1", int'(core_1_stall_o), 1 - (i % 2));
            if (!core_0_stall_o) idx0++;
            if (!core_1_stall_o) idx1 = (idx1 + 1) % 2;
            cyc();
        end
        core_0_rd_i = 1'b0; core_1_rd_i = 1'b0;
        smp();
        chk("rr_data0", int'(core_0_data_o), 'h33);
        chk("rr_data1", int'(core_1_data_o), 'h44);

        // Load against two requesters: both stall, pointer keeps favouring core 0
        cyc();
        store_valid_i = 1'b1; store_core_i = 1'b0; store_data_i = 15'h66;
        core_0_rd_i = 1'b1; core_0_addr_i = 8'd0;
        core_1_rd_i = 1'b1; core_1_addr_i = 8'd1;
        smp();
        chk("ldc_wr_en", int'(ram_wr_en_o), 1);
        chk("ldc_stall0", int'(core_0_stall_o), 1);
        chk("ldc_stall1", int'(core_1_stall_o), 1);
        cyc();
        store_valid_i = 1'b0;
        smp();
        chk("ldc_next_stall0", int'(core_0_stall_o), 0);
        chk("ldc_next_stall1", int'(core_1_stall_o), 1);
        cyc();
        core_0_rd_i = 1'b0;
        smp();
        chk("ldc_late_stall1", int'(core_1_stall_o), 0);
        cyc();
        core_1_rd_i = 1'b0;
        smp();
        chk("ldc_data1", int'(core_1_data_o), 'h55);

        // Reset in the cycle after a core 1 grant
        cyc();
        core_1_rd_i = 1'b1; core_1_addr_i = 8'd0;
        smp();
        chk("prerst_stall1", int'(core_1_stall_o), 0);
        cyc();
        core_1_rd_i = 1'b0; rst_i = 1'b1;
        smp();
        cyc();
        rst_i = 1'b0;
        smp();
        chk("postrst_data1", int'(core_1_data_o), 0);
        chk("postrst_pop0", int'(core_0_populated_o), 0);
        chk("postrst_pop1", int'(core_1_populated_o), 0);
        chk("postrst_ovf", int'(overflow_o), 0);
        cyc();
        core_0_rd_i = 1'b1; core_1_rd_i = 1'b1;
        core_0_addr_i = 8'd0; core_1_addr_i = 8'd0;
        smp();
        chk("postrst_rr_stall0", int'(core_0_stall_o), 0);
        chk("postrst_rr_stall1", int'(core_1_stall_o), 1);
        cyc();
        core_0_rd_i = 1'b0; core_1_rd_i = 1'b0;

        // Fill region 1; the 257th load is dropped and a core 0 fetch takes its slot
        for (int i = 0; i < HALF + 1; i++) begin
            cyc();
            store_valid_i = 1'b1; store_core_i = 1'b1; store_data_i = IW'(i + 1);
            if (i == HALF) begin
                core_0_rd_i = 1'b1; core_0_addr_i = 8'd0;
            end
            smp();
            if (i == HALF) begin
                chk("drop_wr_en", int'(ram_wr_en_o), 0);
                chk("drop_stall0", int'(core_0_stall_o), 0);
            end
        end
        cyc();
        store_valid_i = 1'b0; core_0_rd_i = 1'b0;
        smp();
        chk("full_pop1", int'(core_1_populated_o), 256);
        chk("full_pop0", int'(core_0_populated_o), 0);
        chk("full_ovf", int'(overflow_o), 1);
        chk("full_ram511", int'(ram_mem[511]), 256);
        chk("full_ram0", int'(ram_mem[0]), 'h11);
        chk("full_ram3", int'(ram_mem[3]), 'h66);
        chk("drop_fetch_data0", int'(core_0_data_o), 'h11);
        cyc();
        core_1_rd_i = 1'b1; core_1_addr_i = 8'd255;
        smp();
        cyc();
        core_1_rd_i = 1'b0;
        smp();
        chk("full_data1", int'(core_1_data_o), 256);
        cyc();
        smp();
        chk("ovf_sticky", int'(overflow_o), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
